// File: rtl/ifu_axi_bridge_if.sv
// ifu_axi_bridge_if: fetch request handshake and AXI4-Lite read channels seen by the bridge
interface ifu_axi_bridge_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic [31:0] req_inst;
    logic        req_fault;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        input  req_valid, req_addr, arready, rdata, rresp, rvalid,
        output req_ready, req_inst, req_fault, araddr, arvalid, rready
    );

    modport slave (
        output req_valid, req_addr, arready, rdata, rresp, rvalid,
        input  req_ready, req_inst, req_fault, araddr, arvalid, rready
    );
endinterface

// File: rtl/ifu_axi_bridge.sv
// ifu_axi_bridge: single-outstanding instruction fetch bridge onto an AXI4-Lite read port
module ifu_axi_bridge (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_kill,
    ifu_axi_bridge_if.master  bus,
    output logic [31:0]       o_fetch_cnt,
    output logic [31:0]       o_wait_cnt
);
    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t      r_state;
    logic        r_drop;
    logic        r_resp;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_req_fault;
    logic [31:0] r_araddr;
    logic [31:0] r_req_inst;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_wait_cnt;
    logic        w_req_ready;
    logic        w_drop_now;
    logic        w_busy;

    // A kill arriving in the response cycle still has to hide that response.
    assign w_req_ready = r_resp & ~i_kill;
    assign w_drop_now  = r_drop | i_kill;
    assign w_busy      = (r_state == AR) || (r_state == R);

    assign bus.req_ready = w_req_ready;
    assign bus.req_inst  = r_req_inst;
    assign bus.req_fault = r_req_fault;
    assign bus.araddr    = r_araddr;
    assign bus.arvalid   = r_arvalid;
    assign bus.rready    = r_rready;
    assign o_fetch_cnt   = r_fetch_cnt;
    assign o_wait_cnt    = r_wait_cnt;

    // Fetch sequencer: accept, issue AR, collect R, present one response cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_drop      <= 1'b0;
            r_resp      <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_req_fault <= 1'b0;
            r_araddr    <= '0;
            r_req_inst  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_drop <= 1'b0;
                    if (bus.req_valid && !i_kill) begin
                        r_araddr <= bus.req_addr;
                        if (bus.req_addr[1:0] != 2'b00) begin
                            r_state     <= RESP;
                            r_resp      <= 1'b1;
                            r_req_inst  <= '0;
                            r_req_fault <= 1'b1;
                        end else begin
                            r_state   <= AR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                AR: begin
                    r_drop <= w_drop_now;
                    if (bus.arready) begin
                        r_state   <= R;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                R: begin
                    r_drop <= w_drop_now;
                    if (bus.rvalid) begin
                        r_rready <= 1'b0;
                        if (w_drop_now) begin
                            r_state <= IDLE;
                            r_drop  <= 1'b0;
                        end else begin
                            r_state     <= RESP;
                            r_resp      <= 1'b1;
                            r_req_inst  <= bus.rdata;
                            r_req_fault <= bus.rresp >= 2'd2;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_resp  <= 1'b0;
                end
            endcase
        end
    end

    // Performance counters: delivered fetches and cycles waiting on the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_fetch_cnt <= r_fetch_cnt + 32'(w_req_ready);
            r_wait_cnt  <= r_wait_cnt + 32'(w_busy);
        end
    end
endmodule

// File: tb/tb_ifu_axi_bridge.sv
// tb_ifu_axi_bridge: randomized fetch traffic against a timeline-level reference model
module tb_ifu_axi_bridge;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        kill  = 1'b0;
    logic [31:0] fetch_cnt;
    logic [31:0] wait_cnt;
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] m_inst  = '0;
    logic        m_fault = 1'b0;
    logic [31:0] m_fetch = '0;
    logic [31:0] m_wait  = '0;

    ifu_axi_bridge_if bus();

    ifu_axi_bridge dut (
        .clock       (clock),
        .reset       (reset),
        .i_kill      (kill),
        .bus         (bus),
        .o_fetch_cnt (fetch_cnt),
        .o_wait_cnt  (wait_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " arvalid"}, 32'(bus.arvalid), 0);
        check({tag, " rready"}, 32'(bus.rready), 0);
        check({tag, " req_ready"}, 32'(bus.req_ready), 0);
    endtask

    // One fetch, relative cycle t=0 is the acceptance cycle. The expected
    // timeline follows from the delays: AR lasts ar_dly+1 cycles, R lasts
    // r_dly+1 cycles, then one response cycle (a misaligned address responds
    // at t=1). A kill before the response cycle drops it entirely.
    task automatic run_fetch(input logic [31:0] addr, input int ar_dly, input int r_dly,
                             input int kill_at, input logic [31:0] data, input logic [1:0] resp);
        bit mis     = addr[1:0] != 2'b00;
        int tend    = mis ? 1 : 3 + ar_dly + r_dly;
        bit dropped = kill_at >= 1 && kill_at < tend;
        int ar_seen = 0;
        int r_seen  = 0;
        for (int t = 0; t <= tend; t++) begin
            @(negedge clock);
            bus.req_valid = (t == 0) || (t == tend && !dropped && $urandom_range(1) == 1);
            bus.req_addr  = (t == 0) ? addr : $urandom;
            kill          = (t == kill_at);
            bus.arready   = bus.arvalid ? (ar_seen == ar_dly) : 1'($urandom_range(1));
            bus.rvalid    = bus.rready ? (r_seen == r_dly) : 1'($urandom_range(1));
            bus.rdata     = bus.rready ? data : $urandom;
            bus.rresp     = bus.rready ? resp : 2'($urandom_range(3));
            #1;
            check("arvalid", 32'(bus.arvalid), 32'(!mis && t >= 1 && t <= 1 + ar_dly));
            check("rready", 32'(bus.rready), 32'(!mis && t >= 2 + ar_dly && t <= 2 + ar_dly + r_dly));
            check("req_ready", 32'(bus.req_ready), 32'(t == tend && !dropped && kill_at != tend));
            if (!mis && t >= 1 && t <= 1 + ar_dly) check("araddr", bus.araddr, addr);
            if (t == tend && !dropped) begin
                check("req_inst", bus.req_inst, mis ? 32'h0 : data);
                check("req_fault", 32'(bus.req_fault), 32'(mis ? 1'b1 : resp[1]));
            end
            if (bus.arvalid && !bus.arready) ar_seen++;
            if (bus.rready && !bus.rvalid) r_seen++;
        end
        if (!dropped) begin
            m_inst  = mis ? 32'h0 : data;
            m_fault = mis ? 1'b1 : resp[1];
            if (kill_at != tend) m_fetch++;
        end
        if (!mis) m_wait += 32'(ar_dly + r_dly + 2);
        @(posedge clock);
        #1;
        check("req_inst held", bus.req_inst, m_inst);
        check("req_fault held", 32'(bus.req_fault), 32'(m_fault));
        check("fetch_cnt", fetch_cnt, m_fetch);
        check("wait_cnt", wait_cnt, m_wait);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.arready   = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = '0;
        bus.rvalid    = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_idle_outputs("reset");
        check("reset req_inst", bus.req_inst, 0);
        check("reset req_fault", 32'(bus.req_fault), 0);
        check("reset araddr", bus.araddr, 0);
        check("reset fetch_cnt", fetch_cnt, 0);
        check("reset wait_cnt", wait_cnt, 0);
        reset = 1'b0;

        run_fetch(32'h8000_0000, 0, 0, -1, 32'h0000_0413, 2'b00);
        run_fetch(32'h8000_0010, 3, 2, -1, 32'h1234_5678, 2'b00);
        run_fetch(32'h3000_0002, 0, 0, -1, 32'h0, 2'b00);
        run_fetch(32'h8000_0020, 1, 0, -1, 32'hDEAD_BEEF, 2'b10);
        run_fetch(32'h8000_0000, 0, 2, 2, 32'hCAFE_F00D, 2'b00);
        run_fetch(32'h8000_0004, 0, 0, -1, 32'h0051_0113, 2'b00);
        run_fetch(32'h8000_0008, 0, 0, 1, 32'h1111_1111, 2'b00);
        run_fetch(32'h8000_000C, 1, 1, 4, 32'h2222_2222, 2'b00);
        run_fetch(32'h8000_0010, 0, 1, 4, 32'h3333_3333, 2'b01);
        run_fetch(32'h4000_0001, 0, 0, 1, 32'h0, 2'b00);

        // kill in IDLE must keep the request from being taken
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0040;
        kill          = 1'b1;
        #1;
        check_idle_outputs("kill idle");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
            kill          = 1'b0;
            #1;
            check_idle_outputs("kill idle after");
        end
        @(posedge clock);
        #1;
        check("kill idle wait_cnt", wait_cnt, m_wait);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a = {$urandom} & 32'hFFFF_FFFC;
            int          ad = $urandom_range(3);
            int          rd = $urandom_range(3);
            int          te;
            int          ka = -1;
            if ($urandom_range(4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            te = (a[1:0] != 2'b00) ? 1 : 3 + ad + rd;
            if ($urandom_range(3) == 0) ka = $urandom_range(1, te);
            run_fetch(a, ad, rd, ka, $urandom, 2'($urandom_range(3)));
        end

        // reset while waiting in R
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0100;
        kill          = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.arready   = 1'b1;
        bus.rvalid    = 1'b0;
        @(negedge clock);
        bus.arready   = 1'b0;
        #1;
        check("pre-reset rready", 32'(bus.rready), 1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_idle_outputs("mid reset");
        check("mid reset req_inst", bus.req_inst, 0);
        check("mid reset req_fault", 32'(bus.req_fault), 0);
        check("mid reset araddr", bus.araddr, 0);
        check("mid reset fetch_cnt", fetch_cnt, 0);
        check("mid reset wait_cnt", wait_cnt, 0);
        reset   = 1'b0;
        m_inst  = '0;
        m_fault = 1'b0;
        m_fetch = '0;
        m_wait  = '0;
        run_fetch(32'h8000_0004, 0, 0, -1, 32'h0000_0013, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/ifu_axi_bridge.md
IFU_AXI_BRIDGE -- requirements
Module: ifu_axi_bridge

Interface
REQ-001 The block SHALL have these ports: clock  input  1  system clock; all state updates on rising edge.
REQ-002 The block SHALL have these ports: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have these ports: req_valid  input  1  fetch stage requests a fetch; held high until req_ready.
REQ-004 The block SHALL have these ports: req_addr  input  32  fetch address; sampled only on acceptance.
REQ-005 The block SHALL have these ports: req_ready  output  1  one-cycle pulse; req_inst/req_fault valid this cycle.
REQ-006 The block SHALL have these ports: req_inst  output  32  fetched instruction word (registered).
REQ-007 The block SHALL have these ports: req_fault  output  1  access fault for the returned fetch (registered).
REQ-008 The block SHALL have these ports: kill  input  1  discard the in-flight fetch (redirect).
REQ-009 The block SHALL have these ports: araddr  output  32, arvalid  output  1, arready  input  1  AXI4-Lite read-address channel.
REQ-010 The block SHALL have these ports: rdata  input  32, rresp  input  2, rvalid  input  1, rready  output  1  AXI4-Lite read-data channel.
REQ-011 The block SHALL have these ports: fetch_cnt  output  32  completed fetches; wait_cnt  output  32  cycles spent in AR or R.

Function
REQ-012 The block SHALL implement states IDLE, AR, R, RESP, with exactly one state active per cycle.
REQ-013 IDLE: on req_valid, kill=0, the block SHALL latch req_addr; if req_addr[1:0]!=0, go RESP with req_inst=0, req_fault=1 and no bus access; else go AR.
REQ-014 AR: arvalid SHALL be 1 and araddr SHALL equal the latched address, held stable until arready; on arvalid&arready go R.
REQ-015 R: rready SHALL be 1; on rvalid the block SHALL latch rdata into req_inst, set req_fault=rresp[1], and go RESP.
REQ-016 RESP: req_ready SHALL be 1 for exactly this cycle, then IDLE unconditionally.
REQ-017 arvalid SHALL be 0 outside AR; rready SHALL be 0 outside R; rvalid outside R SHALL be ignored.
REQ-018 Minimum latency, zero-wait slave: req_valid sampled in IDLE at cycle N -> req_ready at cycle N+3.
REQ-019 A new request SHALL NOT be accepted in the RESP cycle; earliest acceptance is the following IDLE cycle.
REQ-020 kill in AR or R SHALL set an internal drop flag; the AXI transaction SHALL still complete (no arvalid withdrawal), and on its completion the block SHALL return to IDLE without req_ready, req_inst/req_fault unchanged.
REQ-021 kill in IDLE SHALL block acceptance that cycle; kill in RESP SHALL suppress req_ready that cycle.
REQ-022 kill and arready or rvalid in the same cycle: the handshake SHALL complete and the response SHALL be dropped.
REQ-023 fetch_cnt SHALL increment by 1 on each req_ready pulse, including faults; wait_cnt SHALL increment each cycle in AR or R; both SHALL wrap modulo 2^32.
REQ-024 The drop flag SHALL clear on return to IDLE.

Reset
REQ-025 With reset=1 at a rising edge: state=IDLE, drop=0, req_ready=0, req_inst=0, req_fault=0, arvalid=0, araddr=0, rready=0, fetch_cnt=0, wait_cnt=0.
REQ-026 Reset SHALL take priority over all other inputs, including mid-transaction; the bench SHALL assume the slave is reset simultaneously.

Verification
REQ-027 Zero-wait slave, req_addr=0x80000000, rdata=0x00000413, rresp=0 -> arvalid cycle N+1, req_ready cycle N+3, req_inst=0x00000413, req_fault=0, fetch_cnt=1.
REQ-028 arready delayed 3 cycles, rvalid delayed 2 -> araddr stable throughout, req_ready at N+8, wait_cnt=7.
REQ-029 req_addr=0x30000002 -> no arvalid, req_ready at N+1, req_inst=0, req_fault=1.
REQ-030 rresp=2'b10, rdata=0xDEADBEEF -> req_ready with req_inst=0xDEADBEEF, req_fault=1.
REQ-031 kill pulse while in R, rvalid two cycles later -> rready handshake completes, no req_ready, fetch_cnt unchanged, next request at 0x80000004 served normally.
REQ-032 reset asserted while in R -> next cycle all outputs at reset values, state IDLE.
